// File: rtl/vm_pkg.sv
// Shared vending-path definitions: coin codes seen on the vending FSM Inp bus
// and the state encoding of the coin emitter.
package vm_pkg;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_ONE   = 2'b01;
    localparam logic [1:0] CODE_TWO   = 2'b10;
    localparam logic [1:0] CODE_THREE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EMIT = 2'b01,
        HOLD = 2'b10
    } emit_state_t;

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-FF synchronizer, debounce filter, rising-edge event
// and a saturating stable-high counter that flags a jammed sensor.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic event_o,
    output logic stable_o,
    output logic jam_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int JW = $clog2(JAM_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [JW-1:0] jcnt_q, jcnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            dcnt_q   <= '0;
            jcnt_q   <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
            jcnt_q   <= jcnt_d;
        end
    end

    always_comb begin
        stable_d = stable_q;
        dcnt_d   = dcnt_q;
        if (sync2_q == stable_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DW'(DEBOUNCE_CYCLES)) begin
            stable_d = sync2_q;
            dcnt_d   = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
        // counts stable-high cycles including the one about to start; clears with stable
        jcnt_d = '0;
        if (stable_d) begin
            jcnt_d = (jcnt_q == JW'(JAM_CYCLES)) ? jcnt_q : jcnt_q + 1'b1;
        end
    end

    assign event_o  = stable_d & ~stable_q;
    assign stable_o = stable_q;
    assign jam_o    = (jcnt_q == JW'(JAM_CYCLES));

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: turns debounced coin events into one-cycle codes for
// the vending FSM, with holdoff spacing, jam gating, drop detection and a credit total.
module coin_acceptor import vm_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 1000,
    parameter int HOLDOFF_CYCLES  = 2,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin_a_raw,
    input  logic             coin_b_raw,
    output logic [1:0]       coin_code,
    output logic             jam,
    output logic             drop_err,
    output logic [CNT_W-1:0] coin_total
);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    logic ev_a, ev_b, stable_a, stable_b, jam_a, jam_b;
    logic take;
    emit_state_t      state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic             drop_q, drop_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W:0]   sum;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_deb_a (
        .clk(clk), .reset(reset), .raw_i(coin_a_raw),
        .event_o(ev_a), .stable_o(stable_a), .jam_o(jam_a)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_deb_b (
        .clk(clk), .reset(reset), .raw_i(coin_b_raw),
        .event_o(ev_b), .stable_o(stable_b), .jam_o(jam_b)
    );

    assign jam  = (jam_a & stable_a) | (jam_b & stable_b);
    assign take = (state_q == IDLE) & (pend_a_q | pend_b_q) & ~jam;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            drop_q   <= 1'b0;
            code_q   <= CODE_NONE;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            drop_q   <= drop_d;
            code_q   <= code_d;
            total_q  <= total_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: if (take) state_d = EMIT;
            EMIT: begin
                state_d = HOLD;
                hold_d  = HW'(HOLDOFF_CYCLES - 1);
            end
            HOLD: begin
                if (hold_q == '0) state_d = IDLE;
                else              hold_d  = hold_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // a new event beats a same-cycle clear, so the pending bit survives
        pend_a_d = ev_a | (pend_a_q & ~take);
        pend_b_d = ev_b | (pend_b_q & ~take);
        drop_d   = (ev_a & pend_a_q & ~take) | (ev_b & pend_b_q & ~take);
        code_d   = take ? {pend_b_q, pend_a_q} : CODE_NONE;
        sum      = {1'b0, total_q} + {{(CNT_W-1){1'b0}}, code_q};
        total_d  = total_q;
        if (state_q == EMIT) total_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    assign coin_code  = code_q;
    assign drop_err   = drop_q;
    assign coin_total = total_q;

endmodule
